// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit bridging a single-cycle core to a variable-latency data memory
// Formats sub-word accesses into aligned transactions with byte enables and extends load data.
module dmem_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              req_ready_q, resp_valid_q, resp_misalign_q, resp_err_q;
  logic              mem_en_q, mem_we_q;
  logic [31:0]       resp_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]        mem_be_q;

  logic              legal_d, misalign_d, to_hit_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d, sh_d, ld_data_d;

  always_comb begin
    legal_d = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal_d = 1'b1;
      3'b100, 3'b101:         legal_d = ~req_write;
      default:                legal_d = 1'b0;
    endcase
    // An illegal size code masks any alignment complaint.
    misalign_d = legal_d &&
                 (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));

    case (req_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase

    sh_d = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data_d = {{24{sh_d[7]}}, sh_d[7:0]};
      3'b001:  ld_data_d = {{16{sh_d[15]}}, sh_d[15:0]};
      3'b100:  ld_data_d = {24'b0, sh_d[7:0]};
      3'b101:  ld_data_d = {16'b0, sh_d[15:0]};
      default: ld_data_d = mem_rdata;
    endcase

    cnt_d    = cnt_q + 1'b1;
    to_hit_d = (TIMEOUT_CYCLES != 0) && (cnt_d == TO_VAL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      f3_q            <= '0;
      off_q           <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_misalign_q <= 1'b0;
      resp_err_q      <= 1'b0;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            f3_q        <= req_funct3;
            off_q       <= req_addr[1:0];
            cnt_q       <= '0;
            if (legal_d && !misalign_d) begin
              state_q     <= ACCESS;
              mem_en_q    <= 1'b1;
              mem_we_q    <= req_write;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_be_q    <= be_d;
            end else begin
              state_q         <= RESP;
              resp_valid_q    <= 1'b1;
              resp_rdata_q    <= '0;
              resp_err_q      <= ~legal_d;
              resp_misalign_q <= misalign_d;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack || to_hit_d) begin
            state_q         <= RESP;
            resp_valid_q    <= 1'b1;
            resp_rdata_q    <= (mem_ack && !mem_we_q) ? ld_data_d : 32'b0;
            resp_err_q      <= ~mem_ack;
            resp_misalign_q <= 1'b0;
            mem_en_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_be_q        <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q         <= IDLE;
          req_ready_q     <= 1'b1;
          cnt_q           <= '0;
          resp_valid_q    <= 1'b0;
          resp_rdata_q    <= '0;
          resp_err_q      <= 1'b0;
          resp_misalign_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign stall         = req_valid & ~resp_valid_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_misalign = resp_misalign_q;
  assign resp_err      = resp_err_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu against a transaction-level model
module tb_dmem_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stall, resp_valid, resp_misalign, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  dmem_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          en_cyc;
    int          resp_k;
    logic [31:0] rd;
    logic        mis;
    logic        err;
  } exp_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-cycle expectations published by the stimulus and consumed by the checker.
  logic        e_chk = 1'b0;
  logic        e_ready, e_stall, e_en, e_rv;
  exp_t        e;
  logic [31:0] last_rdata, seen_wd;
  logic [3:0]  seen_be;
  logic        last_mis, last_err;
  int          rv_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rw, input int ack_k);
    exp_t m;
    int size, off;
    logic legal;
    logic [31:0] v, mask;
    legal  = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off    = int'(a % 4);
    m.mis  = legal && (off % size != 0);
    m.err  = !legal;
    m.we   = wr;
    m.addr = a - 32'(off);
    m.be   = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) m.wd[8*i +: 8] = wd[8*(i % size) +: 8];
    m.rd = 32'b0;
    if (!legal || m.mis) begin
      m.en_cyc = 0;
      m.resp_k = 1;
    end else if (ack_k >= 1 && ack_k <= TO) begin
      m.en_cyc = ack_k;
      m.resp_k = ack_k + 1;
      if (!wr) begin
        v    = rw >> (8 * off);
        mask = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * size)) - 1);
        v    = v & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        m.rd = v;
      end
    end else begin
      m.en_cyc = TO;
      m.resp_k = TO + 1;
      m.err    = 1'b1;
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (e_chk) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("resp_valid", 32'(resp_valid), 32'(e_rv));
      if (e_en) begin
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_be", 32'(mem_be), 32'(e.be));
        chk("mem_wdata", mem_wdata, e.wd);
        seen_be = mem_be;
        seen_wd = mem_wdata;
      end
      if (e_rv) begin
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_misalign", 32'(resp_misalign), 32'(e.mis));
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end else begin
        chk("resp_rdata_idle", resp_rdata, 32'b0);
      end
      if (resp_valid) begin
        rv_count++;
        last_rdata = resp_rdata;
        last_mis   = resp_misalign;
        last_err   = resp_err;
      end
    end
  end

  task automatic set_idle();
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    e_ready   = 1'b1;
    e_stall   = 1'b0;
    e_en      = 1'b0;
    e_rv      = 1'b0;
  endtask

  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int ack_k);
    e = model(wr, f3, a, wd, rw, ack_k);
    for (int k = 0; k <= e.resp_k; k++) begin
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      mem_rdata  = rw;
      mem_ack    = (ack_k != 0) && (k == ack_k);
      e_ready    = (k == 0);
      e_stall    = (k != e.resp_k);
      e_en       = (k >= 1) && (k <= e.en_cyc);
      e_rv       = (k == e.resp_k);
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    exp_t pm;
    rst = 1'b0; req_write = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0;
    set_idle();
    @(posedge clk); #1;
    e_chk = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Hand-computed pins on the model itself.
    pm = model(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1);
    chk("model_lb", pm.rd, 32'hFFFFFF80);
    pm = model(1'b1, 3'b001, 32'h202, 32'h1234, 32'h0, 1);
    chk("model_sh_be", 32'(pm.be), 32'h0000000C);
    chk("model_sh_wd", pm.wd, 32'h12341234);

    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
    chk("lbu_rdata", last_rdata, 32'h00000080);
    run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 2);
    chk("lh_rdata", last_rdata, 32'hFFFF8011);
    run_txn(1'b0, 3'b101, 32'h100, 32'h0, 32'h80112233, 2);
    chk("lhu_rdata", last_rdata, 32'h00002233);
    run_txn(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 1);
    chk("sb_be", 32'(seen_be), 32'h2);
    chk("sb_wd", seen_wd, 32'hA5A5A5A5);
    chk("sb_rdata", last_rdata, 32'h0);
    run_txn(1'b1, 3'b001, 32'h202, 32'h00001234, 32'hFFFFFFFF, 1);
    chk("sh_be", 32'(seen_be), 32'hC);
    chk("sh_wd", seen_wd, 32'h12341234);
    run_txn(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, TO);
    chk("sw_ack_on_timeout_err", 32'(last_err), 32'h0);
    run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h11111111, 1);
    chk("lw_misalign", 32'(last_mis), 32'h1);
    run_txn(1'b1, 3'b100, 32'h200, 32'h55, 32'h0, 1);
    chk("store_f3_100_err", 32'(last_err), 32'h1);
    run_txn(1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 1);
    run_txn(1'b0, 3'b111, 32'h101, 32'h0, 32'h0, 1);
    chk("illegal_misaligned_mis", 32'(last_mis), 32'h0);
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0);
    chk("timeout_err", 32'(last_err), 32'h1);
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, TO + 1);
    chk("late_ack_err", 32'(last_err), 32'h1);
    run_txn(1'b0, 3'b010, 32'h108, 32'h0, 32'h0BADF00D, 1);
    chk("after_timeout_rdata", last_rdata, 32'h0BADF00D);

    // Reset lands mid-access, then a stale ack arrives.
    e = model(1'b0, 3'b010, 32'h400, 32'h0, 32'h77777777, 1);
    rv_count = 0;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; mem_rdata = 32'h77777777;
      req_valid = (k <= 2);
      rst       = (k != 2);
      mem_ack   = (k == 3);
      e_ready   = (k == 0) || (k >= 3);
      e_stall   = (k <= 2);
      e_en      = (k == 1) || (k == 2);
      e_rv      = 1'b0;
    end
    @(posedge clk); #1;
    set_idle();
    chk("reset_no_resp", 32'(rv_count), 32'h0);
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hFEEDC0DE, 2);
    chk("post_reset_lw", last_rdata, 32'hFEEDC0DE);

    @(posedge clk); #1;
    e_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the single-cycle core's data-memory port and a variable-latency data memory. It takes one load or store request from the core and stalls the core until the access completes. It formats byte, halfword and word accesses into word-aligned memory transactions with byte enables, and sign- or zero-extends load data. It also flags misaligned addresses, illegal size codes and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in ACCESS without mem_ack before abort; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
req_valid  input  1  core presents a load/store; held until resp_valid
req_write  input  1  1=store, 0=load
req_funct3  input  3  RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
req_addr  input  32  byte address (ALU result)
req_wdata  input  32  store data (rs2)
req_ready  output  1  high only in IDLE
stall  output  1  combinational: req_valid & ~resp_valid; core holds PC/regfile write while high
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_misalign  output  1  valid with resp_valid
resp_err  output  1  illegal funct3 or timeout; valid with resp_valid
mem_en  output  1  memory request, held until mem_ack
mem_we  output  1  write strobe
mem_addr  output  32  {req_addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables
mem_rdata  input  32  read word, valid with mem_ack
mem_ack  input  1  completion, one cycle

Behaviour:
- Reset (rst==0 at edge): state=IDLE; all outputs 0 except req_ready=1; counter=0. Mid-access reset drops mem_en at that edge; no response issued; later mem_ack ignored.
- States: IDLE, ACCESS, RESP.
- IDLE: accept when req_valid (handshake cycle N). Latch write, funct3, addr[1:0], addr, wdata.
  - Legal and aligned -> ACCESS.
  - Otherwise -> RESP with fault flags set; no memory access.
- Legality: loads accept 000/001/010/100/101; stores accept 000/001/010. Anything else sets resp_err=1.
- Alignment: H/HU need addr[0]==0; W needs addr[1:0]==0. Violation sets resp_misalign=1. If both illegal and misaligned, set resp_err only.
- ACCESS: mem_en=1 from cycle N+1 until and including the mem_ack cycle. mem_we, mem_addr, mem_be, mem_wdata stay stable throughout.
  - On mem_ack: capture mem_rdata; go to RESP.
  - Counter increments each ACCESS cycle without ack. When TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES: drop mem_en, go to RESP with resp_err=1.
  - Ack in the same cycle as timeout: ack wins.
- RESP: resp_valid=1 for exactly one cycle; stall=0; then IDLE with counter cleared. Minimum load/store latency: ack in N+1 gives resp_valid in N+2.
- mem_ack outside ACCESS is ignored.
- Store lanes:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, mem_be=addr[1]?4'b1100:4'b0011.
  - SW: mem_wdata=wdata, mem_be=4'b1111.
- Loads drive mem_be as for the same-size store (informational); mem_we=0.
- Load extract: byte lane mem_rdata[8*addr[1:0]+:8]; half lane mem_rdata[16*addr[1]+:16].
  - B/H sign-extend, BU/HU zero-extend, W as-is.
- resp_rdata holds its value only during resp_valid; 0 otherwise.
- req_valid dropping while not IDLE is a protocol violation; the access still completes.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, ack at N+3 -> mem_en N+1..N+3, mem_addr 0x100, be 1111, resp_valid N+4, rdata 0xDEADBEEF, stall high N..N+3.
- LB/LBU addr 0x103, mem_rdata 0x80112233 -> LB rdata 0xFFFFFF80, LBU 0x00000080; LH addr 0x102 same word -> 0xFFFF8011.
- SB addr 0x201 wdata 0x000000A5 -> mem_we=1, be 0010, wdata 0xA5A5A5A5; SH addr 0x202 wdata 0x1234 -> be 1100, wdata 0x12341234; resp_rdata 0.
- LW addr 0x102 -> no mem_en ever, resp_valid N+1, misalign=1, rdata 0; store funct3 100 -> resp_err=1, no mem_en.
- TIMEOUT_CYCLES=4, no ack -> mem_en 4 cycles, resp_valid with resp_err=1, next request accepted; separately, ack on the 4th cycle -> normal response, err=0.
- rst low during ACCESS, then ack one cycle later -> mem_en 0 after reset edge, no resp_valid, req_ready=1; next LW completes normally.
